// File: rtl/mem_access_pkg.sv
// Shared types and constants for the MEM stage: FSM states, RV32I load/store
// width codes and the access-fault check.
package mem_access_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // True when the width code is illegal or the address is not naturally aligned.
  function automatic logic access_fault(input logic [2:0] funct3, input logic [1:0] addr);
    case (funct3)
      F3_B, F3_BU: return 1'b0;
      F3_H, F3_HU: return addr[0];
      F3_W:        return addr != 2'b00;
      default:     return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/load_extract.sv
// Selects the addressed byte/halfword of a read word and sign- or zero-extends
// it according to the load width code.
module load_extract
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'h0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'h0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores on a ready/valid data bus, stalls
// upstream while the access is in flight and presents the MEM/WB field set.
module mem_access_stage
  import mem_access_pkg::*;
#(
  parameter int unsigned BUS_TIMEOUT = 1023,
  parameter int unsigned CNT_W       = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  input  logic        in_mem_read,
  input  logic        in_mem_write,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_alu_rd_result,
  input  logic [31:0] in_store_data,
  input  logic [4:0]  in_rd_address,
  input  logic        in_reg_write_data_src,
  input  logic        in_reg_wren,
  input  logic [31:0] in_next_pc_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        out_valid,
  output logic [31:0] ram_data,
  output logic [31:0] alu_rd_result,
  output logic [4:0]  rd_address,
  output logic        reg_write_data_src,
  output logic        reg_wren,
  output logic [31:0] next_pc_data,
  output logic        misaligned,
  output logic        bus_error
);

  state_e state_q, state_d;

  logic        read_q, write_q, src_q, wren_q, err_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, sdata_q, npc_q, rdata_q;
  logic [4:0]  rd_q;
  logic [CNT_W-1:0] cnt_q;

  logic        is_mem, exc, start, timeout, req_done, wait_done, abort, latch;
  logic [31:0] extracted;

  assign is_mem = in_mem_read | in_mem_write;
  assign exc    = in_valid & is_mem & access_fault(in_funct3, in_alu_rd_result[1:0]);
  assign start  = in_valid & is_mem & ~exc;

  assign timeout   = (BUS_TIMEOUT != 0) && (cnt_q == CNT_W'(BUS_TIMEOUT - 1));
  assign req_done  = (state_q == StReq) & mem_ready & (~read_q | mem_rvalid);
  assign wait_done = (state_q == StWait) & mem_rvalid;
  // A completing handshake wins over a watchdog expiry in the same cycle.
  assign abort     = (state_q inside {StReq, StWait}) & ~req_done & ~wait_done & timeout;
  assign latch     = read_q & (req_done | wait_done);

  load_extract u_load_extract (
    .rdata  (mem_rdata),
    .addr   (addr_q[1:0]),
    .funct3 (funct3_q),
    .data   (extracted)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (start) state_d = StReq;
      StReq: begin
        if (req_done || abort) state_d = StDone;
        else if (mem_ready)    state_d = StWait;
      end
      StWait: if (wait_done || abort) state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      src_q    <= 1'b0;
      wren_q   <= 1'b0;
      err_q    <= 1'b0;
      funct3_q <= 3'b0;
      addr_q   <= 32'h0;
      sdata_q  <= 32'h0;
      npc_q    <= 32'h0;
      rdata_q  <= 32'h0;
      rd_q     <= 5'h0;
      cnt_q    <= '0;
    end else if (state_q == StIdle) begin
      if (start) begin
        read_q   <= in_mem_read;
        write_q  <= in_mem_write;
        src_q    <= in_reg_write_data_src;
        wren_q   <= in_reg_wren;
        funct3_q <= in_funct3;
        addr_q   <= in_alu_rd_result;
        sdata_q  <= in_store_data;
        npc_q    <= in_next_pc_data;
        rd_q     <= in_rd_address;
        rdata_q  <= 32'h0;
        err_q    <= 1'b0;
        cnt_q    <= '0;
      end
    end else if (state_q == StReq || state_q == StWait) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (latch) rdata_q <= extracted;
      if (abort) err_q <= 1'b1;
    end
  end

  // Bus-side signals come only from the hold registers so they stay stable.
  always_comb begin
    mem_addr = {addr_q[31:2], 2'b00};
    mem_we   = write_q & ~read_q;
    case (funct3_q[1:0])
      2'b00: begin
        mem_be    = 4'b0001 << addr_q[1:0];
        mem_wdata = {4{sdata_q[7:0]}};
      end
      2'b01: begin
        mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        mem_wdata = {2{sdata_q[15:0]}};
      end
      default: begin
        mem_be    = 4'b1111;
        mem_wdata = sdata_q;
      end
    endcase
  end

  always_comb begin
    mem_req            = 1'b0;
    stall              = 1'b0;
    out_valid          = 1'b0;
    misaligned         = 1'b0;
    bus_error          = 1'b0;
    ram_data           = 32'h0;
    alu_rd_result      = addr_q;
    rd_address         = rd_q;
    reg_write_data_src = src_q;
    reg_wren           = wren_q;
    next_pc_data       = npc_q;
    case (state_q)
      StIdle: begin
        stall              = start;
        out_valid          = in_valid & (~is_mem | exc);
        misaligned         = exc;
        alu_rd_result      = in_alu_rd_result;
        rd_address         = in_rd_address;
        reg_write_data_src = in_reg_write_data_src;
        reg_wren           = in_reg_wren & ~exc;
        next_pc_data       = in_next_pc_data;
      end
      StReq: begin
        mem_req = 1'b1;
        stall   = 1'b1;
      end
      StWait: stall = 1'b1;
      default: begin
        out_valid = 1'b1;
        ram_data  = rdata_q;
        reg_wren  = wren_q & ~err_q;
        bus_error = err_q;
      end
    endcase
    if (!reset_n) begin
      mem_req    = 1'b0;
      stall      = 1'b0;
      out_valid  = 1'b0;
      misaligned = 1'b0;
      bus_error  = 1'b0;
    end
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM pipeline stage, directly upstream of the MEM/WB pipeline register.
- Takes one instruction per cycle from EX/MEM.
- Performs loads and stores on a ready/valid data-memory bus: byte enables, lane alignment, load sign/zero extension.
- Drives the exact field set the MEM/WB register captures, plus a stall back to the upstream stages.

Parameters:
- BUS_TIMEOUT, 1023: max cycles in REQ+WAIT before the op aborts with bus_error; 0 disables the watchdog.
- CNT_W, 10: width of the watchdog counter; must hold BUS_TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset_n  in  1  synchronous active-low reset; sampled on posedge clk.
- in_valid  in  1  EX/MEM holds a valid instruction.
- in_mem_read  in  1  instruction is a load.
- in_mem_write  in  1  instruction is a store.
- in_funct3  in  3  RV32I load/store width code.
- in_alu_rd_result  in  32  effective address (mem ops) or ALU result.
- in_store_data  in  32  rs2 value for stores.
- in_rd_address  in  5  destination register.
- in_reg_write_data_src  in  1  1 = writeback takes ram_data.
- in_reg_wren  in  1  register-file write enable.
- in_next_pc_data  in  32  pc+4, passed through.
- mem_req  out  1  bus request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
- mem_wdata  out  32  lane-replicated store data.
- mem_be  out  4  byte enables.
- mem_ready  in  1  bus accepts the request this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read word.
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle.
- out_valid  out  1  MEM/WB wren.
- ram_data  out  32  extracted load data.
- alu_rd_result  out  32  passed-through address or ALU result.
- rd_address  out  5  passed through.
- reg_write_data_src  out  1  passed through.
- reg_wren  out  1  passed through; forced 0 on an exception.
- next_pc_data  out  32  passed through.
- misaligned  out  1  one-cycle flag: misaligned address or illegal funct3.
- bus_error  out  1  one-cycle flag: watchdog expired.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low, reset_n.
  - While reset_n=0: next state IDLE; hold registers and watchdog counter clear to 0.
  - mem_req, stall, out_valid, misaligned and bus_error are gated to 0 while reset_n=0.
  - Reset mid-transaction drops mem_req on the next edge regardless of the handshake; a late mem_rvalid is ignored in IDLE.
- States: IDLE, REQ, WAIT, DONE.
- IDLE, non-memory op (in_valid and neither read nor write):
  - Zero-latency combinational pass-through.
  - out_valid=1, ram_data=0, stall=0.
- IDLE, memory op with a legal, aligned access:
  - stall=1, out_valid=0.
  - Capture all in_* fields into hold registers; go to REQ.
- IDLE, memory op with an exception:
  - Cause: LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0; funct3 011, 110 or 111.
  - No bus request is issued.
  - misaligned=1, out_valid=1 with reg_wren=0, stall=0; stay in IDLE.
- in_mem_read and in_mem_write both 1: the op is treated as a load.
- REQ:
  - mem_req=1; mem_addr, mem_we, mem_be and mem_wdata come from the hold registers and stay stable until mem_ready.
  - Store with mem_ready: go to DONE.
  - Load with mem_ready and mem_rvalid in the same cycle: latch the extracted data, go to DONE.
  - Load with mem_ready only: go to WAIT.
- WAIT: mem_req=0; on mem_rvalid, latch the extracted data and go to DONE.
- DONE:
  - out_valid=1 and all outputs come from the hold registers; stall=0, so upstream advances on this edge.
  - in_* is ignored; next state IDLE.
- stall=1 in REQ and WAIT.
- Watchdog:
  - Counter clears on entry to REQ and increments every cycle in REQ/WAIT.
  - On reaching BUS_TIMEOUT: go to DONE with reg_wren=0, and raise bus_error for the single DONE cycle.
- Store lane generation (a = addr[1:0]):
  - SB: mem_be = 4'b0001 << a; byte replicated ×4.
  - SH: mem_be = 4'b0011 << (2*addr[1]); halfword replicated ×2.
  - SW: mem_be = 4'b1111.
- Load extraction:
  - LB/LBU: select byte a; LH/LHU: select halfword addr[1]; LW: whole word.
  - LB and LH sign-extend; LBU and LHU zero-extend.
- Store latency: 1 cycle in IDLE + 1 cycle per REQ cycle + 1 cycle in DONE (zero-wait store: 3 cycles total).

Decomposition:
- mem_access_pkg: state enum (IDLE/REQ/WAIT/DONE); funct3 localparams F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
- One combinational sub-module, load_extract: inputs rdata, addr[1:0], funct3; output 32-bit extended data. Reused by the bench's reference model.

Test Plan:
- ALU op with in_alu_rd_result=0x1234: out_valid=1, alu_rd_result=0x1234, stall=0 in the same cycle.
- LB at addr 0x103, mem_rdata=0x80FF_FF00, zero-wait bus: mem_addr=0x100; ram_data=0xFFFF_FF80; stall high exactly 2 cycles; out_valid in cycle 3.
- SH at 0x202, data 0xABCD_1234, mem_ready delayed 3 cycles: mem_be=1100, mem_wdata=0x1234_1234, address and data held stable; DONE after accept.
- LW at 0x005: misaligned=1, no mem_req, reg_wren=0, stall=0.
- LHU at 0x002 with mem_ready in cycle 1 and mem_rvalid 4 cycles later, rdata=0xF00D_0000: ram_data=0x0000_F00D.
- BUS_TIMEOUT=8, mem_ready tied low: bus_error pulses after 8 REQ cycles; reg_wren=0; next op proceeds. Separately, reset_n low mid-REQ: mem_req=0 next cycle, state IDLE.
